// File: rtl/rr_sched_pkg.sv
// Shared types and constants for the rotating-priority request scheduler.
package rr_sched_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} sched_state_t;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bcd7seg.sv
// BCD to active-low 7-segment decoder, segments ordered {g,f,e,d,c,b,a}.
module bcd7seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/rr_pick8.sv
// Rotating search: first set request at or after ptr, wrapping modulo 8.
module rr_pick8
    import rr_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_req_scheduler.sv
// Fair, time-bounded sharing of the display between 8 requesters; one grant
// at a time, each held for at most HOLD_MAX cycles, followed by one gap cycle.
module rr_req_scheduler
    import rr_sched_pkg::*;
#(
    parameter  int HOLD_MAX = 16,
    localparam int CNT_W    = $clog2(HOLD_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             ena,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic [6:0]       h
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    sched_state_t     state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             vld_q;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             release_now;
    logic [6:0]       seg_digit;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Only the owner's own request line, enable and the hold budget matter here.
    assign release_now = !req[idx_q] || !ena || (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                GRANT: begin
                    if (release_now) begin
                        state_q <= RELEASE;
                        gnt_q   <= '0;
                        vld_q   <= 1'b0;
                        ptr_q   <= idx_q + IDX_W'(1);
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                IDLE, RELEASE: begin
                    if (ena && pick_found) begin
                        state_q <= GRANT;
                        gnt_q   <= onehot8(pick_idx);
                        idx_q   <= pick_idx;
                        vld_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    bcd7seg u_seg (
        .bcd ({1'b0, idx_q}),
        .seg (seg_digit)
    );

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
    assign h       = vld_q ? seg_digit : SEG_BLANK;

endmodule

// File: tb/tb_rr_req_scheduler.sv
// Bench for rr_req_scheduler: two instances (HOLD_MAX 16 and 4) driven in
// lockstep and compared every cycle against a cycle-level reference model.
module tb_rr_req_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       ena = 1'b1;

    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       vld_a, vld_b;
    logic [6:0] h_a, h_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_req_scheduler #(.HOLD_MAX(16)) dut_a (
        .clk(clk), .rst(rst), .req(req), .ena(ena),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a), .h(h_a)
    );

    rr_req_scheduler #(.HOLD_MAX(4)) dut_b (
        .clk(clk), .rst(rst), .req(req), .ena(ena),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b), .h(h_b)
    );

    // Reference: a grant is either active (owner, cycles held) or not.
    // The mandatory gap falls out naturally: a release cycle cannot also grant.
    int hold_max [2] = '{16, 4};
    int m_busy   [2];
    int m_owner  [2];
    int m_held   [2];
    int m_ptr    [2];

    logic [6:0] seg_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                7'h19, 7'h12, 7'h02, 7'h78};

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic model_step(input int m);
        int p;
        if (rst) begin
            m_busy[m] = 0; m_owner[m] = 0; m_held[m] = 0; m_ptr[m] = 0;
        end else if (m_busy[m] != 0) begin
            if (!req[m_owner[m]] || !ena || m_held[m] == hold_max[m] - 1) begin
                m_busy[m] = 0;
                m_ptr[m]  = (m_owner[m] + 1) % 8;
                m_held[m] = 0;
            end else begin
                m_held[m]++;
            end
        end else begin
            p = pick(req, m_ptr[m]);
            if (ena && p >= 0) begin
                m_busy[m] = 1; m_owner[m] = p; m_held[m] = 0;
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        assert (act === exp_v) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp_v, $time);
        end
    endtask

    task automatic check_dut(input int m, input logic [7:0] g, input logic [2:0] i,
                             input logic v, input logic [6:0] hh);
        logic [7:0] eg;
        logic [6:0] eh;
        eg = (m_busy[m] != 0) ? (8'h01 << m_owner[m]) : 8'h00;
        eh = (m_busy[m] != 0) ? seg_tab[m_owner[m]] : 7'h7F;
        cmp(m == 0 ? "gnt_h16" : "gnt_h4", g, eg);
        cmp(m == 0 ? "idx_h16" : "idx_h4", {5'b0, i}, 8'(m_owner[m]));
        cmp(m == 0 ? "vld_h16" : "vld_h4", {7'b0, v}, 8'(m_busy[m]));
        cmp(m == 0 ? "seg_h16" : "seg_h4", {1'b0, hh}, {1'b0, eh});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_dut(0, gnt_a, idx_a, vld_a, h_a);
        check_dut(1, gnt_b, idx_b, vld_b, h_b);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        // Reset and idle with no requests.
        rst = 1'b1; req = 8'h00; ena = 1'b1;
        ticks(2);
        cmp("rst_h_blank", {1'b0, h_a}, 8'h7F);
        cmp("rst_gnt_zero", gnt_b, 8'h00);
        rst = 1'b0;
        ticks(10);

        // Single request from 5, then drop.
        req = 8'h20;
        tick();
        cmp("single_gnt", gnt_a, 8'h20);
        cmp("single_h5", {1'b0, h_a}, 8'h12);
        ticks(3);
        req = 8'h00;
        ticks(3);

        // Two requesters wrapping through 7 -> 0.
        req = 8'h81;
        ticks(25);
        req = 8'h00;
        ticks(3);

        // Sole requester hitting the hold limit repeatedly.
        req = 8'h08;
        ticks(55);
        req = 8'h00;
        ticks(3);

        // Enable drop mid-grant of requester 2.
        req = 8'h04;
        ticks(2);
        cmp("ena_pre_idx2", {5'b0, idx_a}, 8'd2);
        req = 8'hFF; ena = 1'b0;
        tick();
        cmp("ena_drop_gnt", gnt_a, 8'h00);
        ticks(5);
        ena = 1'b1;
        tick();
        cmp("ena_resume_idx3", {5'b0, idx_a}, 8'd3);
        cmp("ena_resume_gnt", gnt_b, 8'h08);
        ticks(10);

        // Reset pulse during a grant of requester 6.
        req = 8'h00;
        ticks(3);
        req = 8'h40;
        ticks(2);
        cmp("pre_rst_gnt6", gnt_a, 8'h40);
        req = 8'hFF; rst = 1'b1;
        tick();
        cmp("mid_rst_gnt", gnt_a, 8'h00);
        rst = 1'b0;
        tick();
        cmp("post_rst_gnt0", gnt_a, 8'h01);
        ticks(5);

        // Randomized traffic with occasional enable drops and resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
            ena = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_req_scheduler.md
Name: rr_req_scheduler

Overview:
- Sequential scheduler that shares one display resource between 8 requesters, granting one requester at a time.
- Arbitration is rotating-priority. Each grant has a maximum hold time.
- Outputs the one-hot grant, the encoded index with a valid flag, and a 7-segment rendering of the granted index.
- Sits between board switches/requesters and the seven-segment display path. It replaces the fixed-priority 8-to-3 encode stage with a fair, time-bounded sequencer.

Parameters:
- HOLD_MAX, 16: maximum GRANT cycles per grant; legal range 2..256.
- CNT_W, $clog2(HOLD_MAX): hold-counter width; derived, not overridden.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request lines; bit i = requester i; level-sensitive.
- ena  in  1  scheduler enable; low blocks new grants and ends the current one.
- gnt  out  8  one-hot grant, registered; all-zero when no grant.
- gnt_idx  out  3  binary index of the granted requester; holds its last value when gnt_vld=0.
- gnt_vld  out  1  high iff gnt != 0.
- h  out  7  active-low segments {g,f,e,d,c,b,a}; digit gnt_idx when gnt_vld=1, else blank 7'b1111111.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, ptr=0, cnt=0, gnt=0, gnt_idx=0, gnt_vld=0.
  - h=7'b1111111 from the cycle after the reset edge.
  - rst dominates every other input, including mid-grant; the grant is dropped immediately with no RELEASE cycle.
- Pick function (combinational):
  - Over req, search indices ptr, ptr+1, ..., ptr+7, all mod 8.
  - Return the first set bit and found=1; if req==0, found=0.
- State IDLE:
  - If ena && found: load gnt=onehot(pick), gnt_idx=pick, gnt_vld=1, cnt=0; go GRANT.
  - Latency: req rising in cycle N gives gnt_vld=1 after edge N+1.
  - Otherwise stay in IDLE.
- State GRANT:
  - Release condition = !req[gnt_idx] || !ena || cnt==HOLD_MAX-1.
  - If release: gnt=0, gnt_vld=0, ptr=(gnt_idx+1) mod 8 (3-bit wrap, 7 -> 0), cnt=0; go RELEASE.
  - Else: cnt=cnt+1; gnt and gnt_idx unchanged.
  - A granted requester therefore holds for at most HOLD_MAX cycles.
  - Requests from other requesters during GRANT are ignored, never latched.
- State RELEASE (exactly one cycle, gnt_vld=0):
  - Evaluate pick using the updated ptr.
  - If ena && found: grant as in IDLE and go GRANT. Back-to-back grants are separated by exactly one idle cycle.
  - Else go IDLE.
- Fairness / timeout:
  - A requester that times out while still requesting is re-granted only after every other active requester has been served once.
  - Sole requester on timeout: RELEASE cycle, then re-granted.
- Simultaneous events:
  - ena falling in the same cycle as timeout: a single release; ptr advances once.
  - req[gnt_idx] dropping in the same cycle as timeout: a single release.
- h output:
  - Combinational decode of the registered gnt_idx/gnt_vld; no extra latency beyond gnt_vld.
  - Digits 0-7 use the standard 7-segment patterns.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_vld == |gnt.
  - No X on any output after the first reset.

Decomposition:
- Package rr_sched_pkg:
  - typedef enum logic [1:0] {IDLE, GRANT, RELEASE} sched_state_t.
  - localparam N_REQ=8, IDX_W=3.
  - localparam SEG_BLANK=7'b1111111.
  - Function onehot8(idx).
- Sub-module rr_pick8 (combinational): inputs req[7:0] and ptr[2:0]; outputs idx[2:0] and found.
- Segment decode reuses the team's existing bcd7seg decoder, with the blank mux outside it.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, req=8'h00, ena=1 -> gnt=0, gnt_vld=0, h=7'h7F; stays so for 10 cycles.
- Single request: req=8'h20 asserted in cycle 0 -> gnt=8'h20, gnt_idx=5, gnt_vld=1 after edge 1, h shows "5". req drops at cycle 4 -> RELEASE, gnt=0 next cycle, ptr=6.
- Round-robin: req=8'h81 held, HOLD_MAX=4 -> grant order idx 0, 7, 0, 7; each grant lasts 4 cycles with a 1-cycle gap; gnt_idx 7 wraps ptr to 0.
- Timeout with sole requester: req=8'h08 held, HOLD_MAX=16 -> grant 16 cycles, 1 cycle gnt_vld=0, re-grant idx 3; repeat 3 times.
- ena drop: mid-grant of idx 2, ena=0 -> gnt=0 after the next edge; no new grant while ena=0 with req=8'hFF. ena=1 -> next grant is idx 3.
- Reset mid-grant: grant idx 6 active, rst pulsed 1 cycle -> gnt=0, ptr=0. After rst with req=8'hFF -> first grant is idx 0.
